// File: rtl/sram_controller.sv
// sram_controller: serves 32-bit data-memory requests as two 16-bit accesses to an async SRAM
// Optional feature macro: SRAM_READ_BUFFER_EN (one-entry read buffer; reads of the held word hit in IDLE)
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   wrEn, rdEn               request levels, held by the pipeline while ready=0
//   address, writeData       byte address and store data
//   readData                 last completed read word
//   ready                    1 = no access pending / access finishing this cycle
//   sramAddress              halfword address to SRAM
//   sramDqOut/sramDqIn       SRAM data out/in, sramDqOe enables the driver
//   sramWeN                  SRAM write strobe, active low
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  logic              rdEn,
    input  logic [31:0]       address,
    input  logic [31:0]       writeData,
    output logic [31:0]       readData,
    output logic              ready,
    output logic [ADDR_W-1:0] sramAddress,
    output logic [15:0]       sramDqOut,
    input  logic [15:0]       sramDqIn,
    output logic              sramDqOe,
    output logic              sramWeN
);
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_CYCLES);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    state_t state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [31:0] offset;
    logic [ADDR_W-2:0] widx, widx_q;
    logic [31:0] wdata_q;
    logic [15:0] lo_buf;
    logic wr_q, last, req, hit, start, unused;
    assign offset = address - 32'(BASE_ADDR);
    // Taking only [ADDR_W:2] makes out-of-range addresses wrap on the word index
    assign widx = offset[ADDR_W:2];
    assign unused = &{1'b0, offset[31:ADDR_W+1], offset[1:0]};
    assign last = cnt == CNT_MAX;
    assign req = rdEn | wrEn;
    assign start = state == IDLE && req && !hit;
`ifdef SRAM_READ_BUFFER_EN
    logic [ADDR_W-2:0] tag;
    logic valid;
    assign hit = rdEn && !wrEn && valid && tag == widx;
`else
    assign hit = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready      = 1'b0;
        sramDqOe   = 1'b0;
        sramWeN    = 1'b1;
        sramDqOut  = 16'h0;
        case (state)
            IDLE: begin
                ready = ~req | hit;
                if (start) begin
                    state_next = LO;
                    cnt_next   = '0;
                end
            end
            LO, HI: begin
                sramDqOe  = wr_q;
                // Last count of each half is a hold cycle with the strobe released
                sramWeN   = ~(wr_q & ~last);
                sramDqOut = wr_q ? (state == HI ? wdata_q[31:16] : wdata_q[15:0]) : 16'h0;
                cnt_next  = last ? '0 : cnt + CW'(1);
                if (last) state_next = state == LO ? HI : DONE;
            end
            default: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            readData    <= '0;
            sramAddress <= '0;
            widx_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            lo_buf      <= '0;
`ifdef SRAM_READ_BUFFER_EN
            tag         <= '0;
            valid       <= 1'b0;
`endif
        end else begin
            if (start) begin
                widx_q      <= widx;
                wdata_q     <= writeData;
                wr_q        <= wrEn;
                sramAddress <= {widx, 1'b0};
            end
            if (state == LO && last) begin
                sramAddress <= {widx_q, 1'b1};
                if (!wr_q) lo_buf <= sramDqIn;
            end
            if (state == HI && last) begin
                if (!wr_q) readData <= {sramDqIn, lo_buf};
`ifdef SRAM_READ_BUFFER_EN
                if (!wr_q) begin
                    tag   <= widx_q;
                    valid <= 1'b1;
                end else if (valid && tag == widx_q) begin
                    readData <= wdata_q;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: randomized transaction-level check of sram_controller against a word-memory model
module tb_sram_controller;
    localparam int WAIT = 1;
    localparam int LAT  = 2 * WAIT + 3;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wrEn = 1'b0;
    logic        rdEn = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic [31:0] readData;
    logic        ready;
    logic [17:0] sramAddress;
    logic [15:0] sramDqOut;
    logic [15:0] sramDqIn;
    logic        sramDqOe;
    logic        sramWeN;
    logic [15:0] sram [0:(1<<18)-1];
    logic [31:0] ref_mem [int];
    logic [31:0] exp_rd = '0;
    int          tag = 0;
    logic        tag_v = 1'b0;
    int          vecs = 0;
    int          errs = 0;

    sram_controller #(.BASE_ADDR(1024), .ADDR_W(18), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst(rst), .wrEn(wrEn), .rdEn(rdEn), .address(address),
        .writeData(writeData), .readData(readData), .ready(ready),
        .sramAddress(sramAddress), .sramDqOut(sramDqOut), .sramDqIn(sramDqIn),
        .sramDqOe(sramDqOe), .sramWeN(sramWeN)
    );

    always #5 clk = ~clk;

    assign sramDqIn = sram[sramAddress];
    always @(posedge clk) if (!sramWeN) sram[sramAddress] <= sramDqOut;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        int n, we_cnt, idx;
        logic hit;
        logic [17:0] a0, a1;
        logic [15:0] d0, d1;
        idx = int'(((a - 32'd1024) >> 2) & 32'h1FFFF);
        hit = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
`ifdef SRAM_READ_BUFFER_EN
        hit = r && !w && tag_v && tag == idx;
`endif
        @(posedge clk); #1;
        wrEn = w; rdEn = r; address = a; writeData = d;
        n = 0;
        we_cnt = 0;
        forever begin
            @(negedge clk);
            if (!sramWeN) begin
                check("oe_during_we", 32'(sramDqOe), 32'd1);
                if (we_cnt == 0) begin
                    a0 = sramAddress;
                    d0 = sramDqOut;
                end
                a1 = sramAddress;
                d1 = sramDqOut;
                we_cnt++;
            end
            if (ready || n >= 40) break;
            n++;
        end
        check("latency", n, hit ? 0 : LAT);
        check("we_cycles", we_cnt, w ? 2 * WAIT : 0);
        if (w) begin
            ref_mem[idx] = d;
            check("lo_addr", 32'(a0), 32'(2 * idx));
            check("lo_data", 32'(d0), 32'(d[15:0]));
            check("hi_addr", 32'(a1), 32'(2 * idx + 1));
            check("hi_data", 32'(d1), 32'(d[31:16]));
`ifdef SRAM_READ_BUFFER_EN
            if (tag_v && tag == idx) exp_rd = d;
`endif
        end else if (r) begin
            exp_rd = ref_mem[idx];
            tag = idx;
            tag_v = 1'b1;
        end
        check("readData", readData, exp_rd);
        @(posedge clk); #1;
        wrEn = 1'b0; rdEn = 1'b0;
        if (w) begin
            check("sram_lo", 32'(sram[2 * idx]), 32'(d[15:0]));
            check("sram_hi", 32'(sram[2 * idx + 1]), 32'(d[31:16]));
        end
    endtask

    initial begin
        logic w, r;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_wen", 32'(sramWeN), 32'd1);
        check("rst_oe", 32'(sramDqOe), 32'd0);
        check("rst_rdata", readData, 32'd0);
        check("rst_addr", 32'(sramAddress), 32'd0);
        access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1032, 32'h0);
        access(1'b1, 1'b1, 32'd1024, 32'h12345678);
        access(1'b0, 1'b1, 32'd1024, 32'h0);
        access(1'b0, 1'b1, 32'd1032, 32'h0);
        access(1'b1, 1'b0, 32'd1032, 32'hCAFEF00D);
        access(1'b0, 1'b1, 32'd1032, 32'h0);
        for (int k = 0; k < 16; k++) access(1'b1, 1'b0, 32'd1024 + 32'(4 * k), $urandom);
        access(1'b1, 1'b0, 32'd1020, 32'h0BAD_F00D);
        access(1'b0, 1'b1, 32'd1020, 32'h0);
        access(1'b1, 1'b0, 32'd1024 + (32'd1 << 19) + 32'd20, 32'h5555AAAA);
        access(1'b0, 1'b1, 32'd1046, 32'h0);
        for (int t = 0; t < 60; t++) begin
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            a = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a + (32'd1 << 19);
            access(w, r, a, $urandom);
        end
        @(posedge clk); #1;
        wrEn = 1'b1; address = 32'd1036; writeData = 32'hA5A55A5A;
        repeat (4) @(negedge clk);
        check("abort_in_hi", 32'(sramWeN), 32'd0);
        rst = 1'b0;
        wrEn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_wen", 32'(sramWeN), 32'd1);
        check("abort_oe", 32'(sramDqOe), 32'd0);
        check("abort_rdata", readData, 32'd0);
        rst = 1'b1;
        exp_rd = '0;
        tag_v = 1'b0;
        access(1'b1, 1'b0, 32'd1036, 32'h13579BDF);
        access(1'b0, 1'b1, 32'd1036, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
